// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Holds a small program in a DEPTH x 16 register array and hands it to a
//   processor one word at a time. Each word is presented on iin with a
//   one-cycle run pulse; the sequencer then waits for done before fetching
//   the next word. A word of 16'hFFFF halts the sequence once it completes.
//
//   Optional feature: define SEQ_TIMEOUT_EN to add an 8-bit watchdog on the
//   WAIT state and the sticky error output.
//
// Ports
//   clock    : system clock, all state changes on the rising edge
//   resetn   : synchronous reset, active HIGH
//   wr_en    : program-load write strobe (honoured in IDLE/HALT only)
//   wr_addr  : program-load word address
//   wr_data  : program-load word
//   start    : run the program from address 0 (honoured in IDLE/HALT only)
//   done     : processor completion for the word on iin (honoured in WAIT only)
//   iin      : instruction word presented to the processor
//   run      : one-cycle pulse marking a new valid iin
//   pc       : address of the word on iin
//   busy     : high in ISSUE or WAIT
//   halted   : high in HALT
//   error    : sticky watchdog timeout (SEQ_TIMEOUT_EN only)
module instruction_sequencer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic          start,
    input  logic          done,
    output logic [15:0]   iin,
    output logic          run,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
`ifdef SEQ_TIMEOUT_EN
    ,
    output logic          error
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [15:0]   mem [DEPTH];
    logic          loadable;
    logic          mem_we;
    logic          launch;
    logic          advance;
    logic          fetch;
    logic [AW-1:0] fetch_addr;
    logic [15:0]   fetch_word;

    assign loadable = (state == IDLE) || (state == HALT);
    assign mem_we   = wr_en && loadable;
    assign launch   = start && loadable;
    assign advance  = (state == WAIT) && done && (iin != 16'hFFFF);
    assign fetch    = launch || advance;

    // The word is latched into iin on the edge that enters ISSUE, so run and
    // the new iin appear together and a prompt done gives a two-cycle
    // issue-to-issue spacing. pc wraps naturally at AW bits.
    assign fetch_addr = launch ? '0 : pc + AW'(1);

    // A write landing on the same edge as start must be seen by the first
    // fetch, so it is forwarded around the array.
    assign fetch_word = (mem_we && (wr_addr == fetch_addr)) ? wr_data : mem[fetch_addr];

`ifdef SEQ_TIMEOUT_EN
    logic [7:0] wdog;
    logic       timeout;

    // Fires on the WAIT cycle whose increment would bring the count to 255,
    // i.e. exactly 255 cycles after entering WAIT.
    assign timeout = (state == WAIT) && !done && (wdog == 8'hFE);
`endif

    // State register
    always_ff @(posedge clock) begin
        if (resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (done) begin
                    state_nxt = (iin == 16'hFFFF) ? HALT : ISSUE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (timeout) begin
                    state_nxt = HALT;
                end
`endif
            end
            HALT: begin
                if (start) state_nxt = ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode, purely from registered state
    always_comb begin
        run    = (state == ISSUE);
        busy   = (state == ISSUE) || (state == WAIT);
        halted = (state == HALT);
    end

    // Program store, deliberately not reset
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Fetch datapath
    always_ff @(posedge clock) begin
        if (resetn) begin
            pc  <= '0;
            iin <= '0;
        end else if (fetch) begin
            pc  <= fetch_addr;
            iin <= fetch_word;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    // Watchdog and sticky error
    always_ff @(posedge clock) begin
        if (resetn) begin
            wdog  <= '0;
            error <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wdog <= '0;
            end else if ((state == WAIT) && !done) begin
                wdog <= wdog + 8'd1;
            end

            if (timeout) begin
                error <= 1'b1;
            end else if (launch) begin
                error <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter DEPTH, default 16, number of 16-bit program words; power of two, 2..256.
REQ-002 Parameter AW, default 4, address width; equals log2(DEPTH).
REQ-003 clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 resetn  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  program-load write strobe; honoured only in IDLE or HALT.
REQ-006 wr_addr  input  AW  program-load word address.
REQ-007 wr_data  input  16  program-load word.
REQ-008 start  input  1  one-cycle request to run the program from address 0.
REQ-009 done  input  1  processor completion pulse for the instruction currently presented.
REQ-010 iin  output  16  instruction word presented to the processor.
REQ-011 run  output  1  one-cycle pulse marking a new valid iin.
REQ-012 pc  output  AW  address of the instruction on iin.
REQ-013 busy  output  1  high in ISSUE or WAIT.
REQ-014 halted  output  1  high in HALT.
REQ-015 error  output  1  sticky timeout flag; only present when SEQ_TIMEOUT_EN is defined.

Function
REQ-016 Storage shall be a DEPTH x 16 register array, written on the rising edge when wr_en is high and the state is IDLE or HALT; writes in ISSUE or WAIT shall be ignored.
REQ-017 The FSM shall have four states: IDLE, ISSUE, WAIT, HALT.
REQ-018 IDLE: start high -> pc=0, go to ISSUE on the next edge; otherwise remain.
REQ-019 ISSUE (one cycle): iin <= mem[pc] registered, run=1, go to WAIT.
REQ-020 The word presented on iin shall be the memory content at the ISSUE edge; a later write to that address shall not change iin.
REQ-021 WAIT: iin held stable, run=0; on done=1, if iin==16'hFFFF go to HALT, otherwise pc <= pc+1 and go to ISSUE.
REQ-022 Issue-to-issue latency shall be two cycles when done is returned in the cycle after run.
REQ-023 pc increment shall wrap modulo DEPTH: DEPTH-1 -> 0 with no halt.
REQ-024 done shall be ignored in IDLE, ISSUE and HALT.
REQ-025 start shall be ignored in ISSUE and WAIT.
REQ-026 HALT: iin and pc hold their last values; start=1 -> pc=0, go to ISSUE.
REQ-027 A simultaneous wr_en and start in IDLE or HALT shall complete the write first, so the first fetch sees the new word.
REQ-028 busy shall equal (state==ISSUE or WAIT); halted shall equal (state==HALT); both shall be registered-state decodes with no combinational path from inputs.

Reset
REQ-029 When resetn=1 at an edge: state=IDLE, pc=0, iin=16'h0000, run=0, busy=0, halted=0, error=0.
REQ-030 Reset shall take priority over all other inputs, including mid-WAIT, and any pending done shall be discarded.
REQ-031 Program memory contents shall not be cleared by reset.

Configuration
REQ-032 Macro SEQ_TIMEOUT_EN: when defined, an 8-bit watchdog shall clear on entry to WAIT and increment each WAIT cycle without done.
REQ-033 With SEQ_TIMEOUT_EN defined, a watchdog count of 255 shall set error, force HALT, and leave iin and pc frozen; error shall clear only on reset or start.
REQ-034 With SEQ_TIMEOUT_EN undefined, the watchdog and the error port shall be absent, and WAIT shall wait indefinitely.

Verification
REQ-035 Load mem[0..2]=16'h1234,16'h5678,16'hFFFF, pulse start, answer each run with done one cycle later -> three run pulses with iin=1234/5678/FFFF and pc=0/1/2, then halted=1 and busy=0.
REQ-036 Assert resetn during WAIT at pc=1 -> next cycle state IDLE, iin=0, pc=0, run=0; a following start fetches mem[0] unchanged.
REQ-037 DEPTH=4 with no FFFF word, continuous done -> pc sequence 0,1,2,3,0,1 and halted stays 0.
REQ-038 Write to mem[1] while busy -> mem[1] unchanged on its next fetch; the same write in HALT followed by start -> the new value is fetched.
REQ-039 With SEQ_TIMEOUT_EN defined, no done after run -> error=1 and halted=1 exactly 255 cycles after entering WAIT; a subsequent start clears error.
